// File: rtl/lfsr_prbs_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_prbs_gen
// Brief    : Parametrised Galois/Fibonacci LFSR PRBS source on a valid/ready
//            stream, with seed load, lock-up recovery and period measurement.
// Revision : 1.0  initial release
// ============================================================================
module lfsr_prbs_gen #(
  parameter int unsigned      WIDTH  = 16,
  parameter int unsigned      GALOIS = 1,
  parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
  parameter logic [WIDTH-1:0] SEED   = 16'hACE1,
  parameter int unsigned      STEPS  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             lockup,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  localparam logic [WIDTH-1:0] c_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] c_ZERO = '0;

  logic [WIDTH-1:0] state_q,  state_d;
  logic [WIDTH-1:0] start_q,  start_d;
  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q,  valid_d;
  logic             lockup_q, lockup_d;
  logic             wrap_q,   wrap_d;

  logic             w_fire;
  logic [WIDTH-1:0] w_adv;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_chain [0:STEPS];

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    if (GALOIS != 0) begin
      r = (s >> 1) ^ (s[0] ? TAPS : c_ZERO);
    end else begin
      r = {^(s & TAPS), s[WIDTH-1:1]};
    end
    return r;
  endfunction

  // STEPS single shifts unrolled into one combinational advance.
  assign w_chain[0] = state_q;
  for (genvar k = 0; k < STEPS; k++) begin : g_step
    assign w_chain[k+1] = f_shift(w_chain[k]);
  end
  assign w_adv = w_chain[STEPS];

  assign w_fire    = valid_q & out_ready & en;
  assign w_cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + c_ONE;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    valid_d  = en;
    lockup_d = 1'b0;
    wrap_d   = 1'b0;
    if (load) begin
      cnt_d = c_ZERO;
      if (load_value != c_ZERO) begin
        state_d = load_value;
        start_d = load_value;
      end else begin
        state_d  = SEED;
        start_d  = SEED;
        lockup_d = 1'b1;
      end
    end else if (w_fire) begin
      // A zero state is a fixed point of both forms, so only the final
      // result of the unrolled advance needs checking.
      if (w_adv == c_ZERO) begin
        state_d  = SEED;
        lockup_d = 1'b1;
        cnt_d    = w_cnt_inc;
      end else if (w_adv == start_q) begin
        state_d  = w_adv;
        wrap_d   = 1'b1;
        period_d = w_cnt_inc;
        cnt_d    = c_ZERO;
      end else begin
        state_d  = w_adv;
        cnt_d    = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SEED;
      start_q  <= SEED;
      cnt_q    <= c_ZERO;
      period_q <= c_ZERO;
      valid_q  <= 1'b0;
      lockup_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lockup_q <= lockup_d;
      wrap_q   <= wrap_d;
    end
  end

  assign out_data  = state_q;
  assign out_valid = valid_q;
  assign lockup    = lockup_q;
  assign wrap      = wrap_q;
  assign period    = period_q;

endmodule
`default_nettype wire
